laser_bank: RTL

- Multi-shot successor of the single player laser. Holds NUM_LASERS independent laser slots, each moving up one STEP_MOTION per enable tick.
- Fire is rate-limited by a cooldown counter.
- A killed laser shows a hit flash for a fixed number of ticks before its slot is freed.
- Sits between the gun/input logic and the alien collision and pixel mux logic. Produces per-slot positions, an alive mask and a registered pixel colour.

---
 rtl/laser_pkg.sv | 51 +++++
 rtl/laser_slot.sv | 139 +++++++++++++
 rtl/laser_bank.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/laser_pkg.sv
// ---------------------------------------------------------------------------
// laser_pkg
//   Shared definitions for the multi-shot laser bank:
//     - pixel colour codes driven onto colorLaser
//     - slot state encoding (2 bits)
//     - default geometry and timing constants
//     - START_Y derivation and a counter-width helper
// ---------------------------------------------------------------------------
package laser_pkg;

    localparam int unsigned COORD_W = 10;   // screen coordinate width
    localparam int unsigned DIST_W  = 22;   // squared-distance width
    localparam int unsigned COLOR_W = 3;

    // Pixel colour codes
    localparam logic [COLOR_W-1:0] BACKGROUND = 3'd0;
    localparam logic [COLOR_W-1:0] HIT        = 3'd1;
    localparam logic [COLOR_W-1:0] LASER      = 3'd3;

    // Per-slot life cycle
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLYING    = 2'd1,
        EXPLODING = 2'd2
    } slot_state_e;

    // Default geometry / timing
    localparam int unsigned DEF_NUM_LASERS    = 4;
    localparam int unsigned DEF_COOLDOWN      = 20;
    localparam int unsigned DEF_FLASH_TICKS   = 8;
    localparam int unsigned DEF_RADIUS        = 7;
    localparam int unsigned DEF_STEP_MOTION   = 1;
    localparam int unsigned DEF_SCREEN_HEIGHT = 480;
    localparam int unsigned DEF_SHIP_HEIGHT   = 30;
    localparam int unsigned DEF_V_OFFSET      = 10;

    // Launch height: the disc sits just above the ship, whose top edge is
    // SHIP_HEIGHT + V_OFFSET above the bottom of the screen.
    function automatic int unsigned start_y(input int unsigned screen_h,
                                            input int unsigned ship_h,
                                            input int unsigned v_off,
                                            input int unsigned radius);
        return screen_h - v_off - ship_h - radius;
    endfunction

    // Width of a down-counter holding 0..max_val; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/laser_slot.sv
// ---------------------------------------------------------------------------
// laser_slot
//   One laser slot: life-cycle FSM (IDLE -> FLYING -> EXPLODING/IDLE),
//   position registers, hit-flash counter and the disc hit test for the
//   current pixel.
//
// Ports
//   clk         in   pixel clock
//   reset       in   synchronous, active-low reset
//   enable      in   motion tick (one cycle per frame)
//   launch_i    in   allocator picked this slot this cycle (only while IDLE)
//   launch_x_i  in   x to load on launch (gun centre)
//   kill_i      in   collision strobe, honoured only while FLYING
//   hPos_i      in   current pixel x
//   vPos_i      in   current pixel y
//   state_o     out  current slot state
//   x_o, y_o    out  current disc centre (0,0 while IDLE)
//   hit_o       out  current pixel lies inside a non-IDLE disc (combinational)
// ---------------------------------------------------------------------------
module laser_slot
    import laser_pkg::*;
#(
    parameter int unsigned FLASH_TICKS = DEF_FLASH_TICKS,
    parameter int unsigned RADIUS      = DEF_RADIUS,
    parameter int unsigned STEP_MOTION = DEF_STEP_MOTION,
    parameter int unsigned START_Y     = 433
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               launch_i,
    input  logic [COORD_W-1:0] launch_x_i,
    input  logic               kill_i,
    input  logic [COORD_W-1:0] hPos_i,
    input  logic [COORD_W-1:0] vPos_i,
    output slot_state_e        state_o,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               hit_o
);

    localparam int unsigned FLASH_W = cnt_w(FLASH_TICKS);

    localparam logic [COORD_W-1:0] STEP_Y   = COORD_W'(STEP_MOTION);
    localparam logic [COORD_W-1:0] LAUNCH_Y = COORD_W'(START_Y);
    localparam logic [FLASH_W-1:0] FLASH_LD = FLASH_W'(FLASH_TICKS);
    localparam logic [DIST_W-1:0]  R_SQ     = DIST_W'(RADIUS * RADIUS);

    slot_state_e        state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [FLASH_W-1:0] flash_q, flash_d;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            flash_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            flash_q <= flash_d;
        end
    end

    // Next state. A kill takes priority over motion, so a killed disc
    // freezes at the position it had when the strobe arrived.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        flash_d = flash_q;
        unique case (state_q)
            IDLE: begin
                if (launch_i) begin
                    state_d = FLYING;
                    x_d     = launch_x_i;
                    y_d     = LAUNCH_Y;
                end
            end
            FLYING: begin
                if (kill_i) begin
                    state_d = EXPLODING;
                    flash_d = FLASH_LD;
                end else if (enable) begin
                    // Leaving at y <= STEP keeps y from wrapping past 0.
                    if (y_q > STEP_Y) begin
                        y_d = y_q - STEP_Y;
                    end else begin
                        state_d = IDLE;
                        x_d     = '0;
                        y_d     = '0;
                    end
                end
            end
            EXPLODING: begin
                if (enable) begin
                    // The tick that takes the counter to zero frees the slot.
                    if (flash_q <= FLASH_W'(1)) begin
                        state_d = IDLE;
                        x_d     = '0;
                        y_d     = '0;
                        flash_d = '0;
                    end else begin
                        flash_d = flash_q - FLASH_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
                flash_d = '0;
            end
        endcase
    end

    // Outputs: state, position and the disc hit test.
    logic signed [COORD_W:0]  dx, dy;
    logic signed [DIST_W-1:0] dx_w, dy_w;
    logic        [DIST_W-1:0] d_sq;

    always_comb begin
        state_o = state_q;
        x_o     = x_q;
        y_o     = y_q;
        dx      = $signed({1'b0, hPos_i}) - $signed({1'b0, x_q});
        dy      = $signed({1'b0, vPos_i}) - $signed({1'b0, y_q});
        dx_w    = DIST_W'(dx);
        dy_w    = DIST_W'(dy);
        // Max 2*1023^2 fits in 22 bits, so the truncated products are exact.
        d_sq    = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
        hit_o   = (state_q != IDLE) && (d_sq < R_SQ);
    end

endmodule

// File: rtl/laser_bank.sv
// ---------------------------------------------------------------------------
// laser_bank
//   NUM_LASERS independent laser slots with a rate-limited launcher and a
//   registered per-pixel colour output for the pixel mux.
//
// Ports
//   clk           in   pixel clock
//   reset         in   synchronous, active-low reset
//   enable        in   motion tick, one cycle per frame
//   fire          in   fire request, level-sensitive
//   killingAlien  in   per-slot kill strobe from the collision logic
//   gunPosition   in   gun x centre, used as launch x
//   hPos, vPos    in   current pixel coordinates
//   xLaser        out  per-slot x; slot i occupies bits [10i+9:10i]
//   yLaser        out  per-slot y, same packing
//   aliveMask     out  1 = slot FLYING (collision eligible)
//   fireAccepted  out  one-cycle pulse, coincident with the new slot appearing
//   colorLaser    out  colour for (hPos,vPos), one cycle latency
// ---------------------------------------------------------------------------
module laser_bank
    import laser_pkg::*;
#(
    parameter int unsigned NUM_LASERS    = DEF_NUM_LASERS,
    parameter int unsigned COOLDOWN      = DEF_COOLDOWN,
    parameter int unsigned FLASH_TICKS   = DEF_FLASH_TICKS,
    parameter int unsigned RADIUS        = DEF_RADIUS,
    parameter int unsigned STEP_MOTION   = DEF_STEP_MOTION,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int unsigned SHIP_HEIGHT   = DEF_SHIP_HEIGHT,
    parameter int unsigned V_OFFSET      = DEF_V_OFFSET
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               fire,
    input  logic [NUM_LASERS-1:0]              killingAlien,
    input  logic [COORD_W-1:0]                 gunPosition,
    input  logic [COORD_W-1:0]                 hPos,
    input  logic [COORD_W-1:0]                 vPos,
    output logic [NUM_LASERS-1:0][COORD_W-1:0] xLaser,
    output logic [NUM_LASERS-1:0][COORD_W-1:0] yLaser,
    output logic [NUM_LASERS-1:0]              aliveMask,
    output logic                               fireAccepted,
    output logic [COLOR_W-1:0]                 colorLaser
);

    localparam int unsigned START_Y = start_y(SCREEN_HEIGHT, SHIP_HEIGHT,
                                              V_OFFSET, RADIUS);
    localparam int unsigned CD_W    = cnt_w(COOLDOWN);
    localparam logic [CD_W-1:0] CD_LD = CD_W'(COOLDOWN);

    slot_state_e               slot_state [NUM_LASERS];
    logic [NUM_LASERS-1:0]     slot_hit;
    logic [NUM_LASERS-1:0]     slot_idle;
    logic [NUM_LASERS-1:0]     launch;
    logic                      accept;

    logic [CD_W-1:0]           cool_q, cool_d;
    logic                      fire_acc_q;
    logic [COLOR_W-1:0]        color_q, color_d;

    // Slot array
    for (genvar g = 0; g < NUM_LASERS; g++) begin : g_slot
        laser_slot #(
            .FLASH_TICKS (FLASH_TICKS),
            .RADIUS      (RADIUS),
            .STEP_MOTION (STEP_MOTION),
            .START_Y     (START_Y)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .enable     (enable),
            .launch_i   (launch[g]),
            .launch_x_i (gunPosition),
            .kill_i     (killingAlien[g]),
            .hPos_i     (hPos),
            .vPos_i     (vPos),
            .state_o    (slot_state[g]),
            .x_o        (xLaser[g]),
            .y_o        (yLaser[g]),
            .hit_o      (slot_hit[g])
        );
    end

    // Allocator: lowest-index IDLE slot. slot_idle reflects registered
    // state, so a slot freed this cycle only becomes eligible next cycle.
    always_comb begin
        logic found;
        found  = 1'b0;
        launch = '0;
        for (int i = 0; i < NUM_LASERS; i++) begin
            slot_idle[i] = (slot_state[i] == IDLE);
            aliveMask[i] = (slot_state[i] == FLYING);
        end
        // A drop (all busy) leaves the cooldown untouched.
        accept = fire && (cool_q == '0) && (|slot_idle);
        for (int i = 0; i < NUM_LASERS; i++) begin
            if (accept && slot_idle[i] && !found) begin
                launch[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // Cooldown: a fresh load takes precedence over a same-cycle tick.
    always_comb begin
        cool_d = cool_q;
        if (accept) begin
            cool_d = CD_LD;
        end else if (enable && (cool_q != '0)) begin
            cool_d = cool_q - CD_W'(1);
        end
    end

    // Colour priority: scan high to low so the lowest hitting slot wins.
    always_comb begin
        color_d = BACKGROUND;
        for (int i = NUM_LASERS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                color_d = (slot_state[i] == FLYING) ? LASER : HIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cool_q     <= '0;
            fire_acc_q <= 1'b0;
            color_q    <= BACKGROUND;
        end else begin
            cool_q     <= cool_d;
            fire_acc_q <= accept;
            color_q    <= color_d;
        end
    end

    assign fireAccepted = fire_acc_q;
    assign colorLaser   = color_q;

endmodule
